// File: rtl/simple_cic.sv
// Decimating CIC filter: n integrators at the input sample rate, n combs at the
// decimated rate, full-precision W-bit wrapping arithmetic.
module simple_cic #(
    parameter int dw   = 16,
    parameter int n    = 2,
    parameter int rlog = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          g_in,
    input  logic signed [dw-1:0]          d_in,
    output logic                          g_out,
    output logic signed [dw+n*rlog-1:0]   d_out
);
    localparam int W = dw + n * rlog;

    logic signed [W-1:0] x;
    logic signed [W-1:0] integ_q [n];
    logic signed [W-1:0] integ_d [n];
    logic signed [W-1:0] dly_q   [n];
    logic signed [W-1:0] dly_d   [n];
    logic signed [W-1:0] int_acc;
    logic signed [W-1:0] comb_acc;
    logic signed [W-1:0] cn_q;
    logic [rlog-1:0]     cnt_q;
    logic                ev_q;
    logic                cv_q;

    assign x = W'(d_in);

    // Integrator chain: each stage adds the freshly updated value of the one before it.
    always_comb begin
        int_acc = x;
        for (int j = 0; j < n; j++) begin
            int_acc    = int_acc + integ_q[j];
            integ_d[j] = int_acc;
        end
    end

    // Comb chain on the last integrator; each delay captures its stage input.
    always_comb begin
        comb_acc = integ_q[n-1];
        for (int j = 0; j < n; j++) begin
            dly_d[j] = comb_acc;
            comb_acc = comb_acc - dly_q[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < n; j++) begin
                integ_q[j] <= '0;
                dly_q[j]   <= '0;
            end
            cnt_q <= '0;
            ev_q  <= 1'b0;
            cv_q  <= 1'b0;
            cn_q  <= '0;
            g_out <= 1'b0;
            d_out <= '0;
        end else begin
            if (g_in) begin
                integ_q <= integ_d;
                cnt_q   <= cnt_q + 1'b1;
            end
            // Counter at R-1 (all ones) marks the decimation event.
            ev_q <= g_in && (&cnt_q);
            cv_q <= ev_q;
            if (ev_q) begin
                dly_q <= dly_d;
                cn_q  <= comb_acc;
            end
            g_out <= cv_q;
            if (cv_q) begin
                d_out <= cn_q;
            end
        end
    end

endmodule

// File: tb/tb_simple_cic.sv
// Directed bench for simple_cic at default parameters (R=2, n=2):
// y[m] = x[2m+1] + 2x[2m] + x[2m-1], output 2 edges after the event sample.
module tb_simple_cic;
    localparam int DW   = 16;
    localparam int N    = 2;
    localparam int RLOG = 1;
    localparam int W    = DW + N * RLOG;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic                 g_in  = 1'b0;
    logic signed [DW-1:0] d_in  = '0;
    logic                 g_out;
    logic signed [W-1:0]  d_out;

    always #5 clk = ~clk;

    simple_cic #(.dw(DW), .n(N), .rlog(RLOG)) dut (
        .clk   (clk),
        .reset (reset),
        .g_in  (g_in),
        .d_in  (d_in),
        .g_out (g_out),
        .d_out (d_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int outs[$];
    int outc[$];
    int xs[$];
    int kcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && g_out) begin
            outs.push_back(int'(d_out));
            outc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        outs.delete();
        outc.delete();
        xs.delete();
        kcyc.delete();
    endtask

    task automatic cyc_in(input bit g, input int d);
        g_in = g;
        d_in = d[DW-1:0];
        @(posedge clk);
        #1;
        if (g) begin
            xs.push_back(d);
            kcyc.push_back(cyc);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) cyc_in(1'b0, 0);
    endtask

    task automatic do_reset();
        g_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    function automatic int model(input int m);
        int y;
        y = xs[2*m+1] + 2 * xs[2*m];
        if (m > 0) y = y + xs[2*m-1];
        return y;
    endfunction

    // Compare every captured output and its latency against the model.
    task automatic check_stream(input string tag);
        int nexp;
        nexp = xs.size() / 2;
        check_eq({tag, "_count"}, outs.size(), nexp);
        for (int m = 0; m < nexp && m < outs.size(); m++) begin
            check_eq($sformatf("%s_y%0d", tag, m), outs[m], model(m));
            check_eq($sformatf("%s_lat%0d", tag, m), outc[m] - kcyc[2*m+1], 2);
        end
    endtask

    initial begin
        // Held in reset with activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            cyc_in(i[0], 1234);
            check_eq("rst_g_out", int'(g_out), 0);
            check_eq("rst_d_out", int'(d_out), 0);
        end
        g_in = 1'b0;
        do_reset();

        // DC 1000 back-to-back.
        for (int i = 0; i < 8; i++) cyc_in(1'b1, 1000);
        drain();
        check_stream("dc");
        check_eq("dc_first", outs[0], 3000);
        check_eq("dc_steady", outs[1], 4000);
        check_eq("dc_period", outc[1] - outc[0], 2);
        check_eq("dc_hold", int'(d_out), 4000);
        check_eq("dc_idle_g", int'(g_out), 0);

        // Impulse at x[1].
        do_reset();
        cyc_in(1'b1, 0);
        cyc_in(1'b1, 1);
        for (int i = 0; i < 4; i++) cyc_in(1'b1, 0);
        drain();
        check_eq("imp1_n", outs.size(), 3);
        check_eq("imp1_y0", outs[0], 1);
        check_eq("imp1_y1", outs[1], 1);
        check_eq("imp1_y2", outs[2], 0);

        // Impulse at x[0].
        do_reset();
        cyc_in(1'b1, 1);
        for (int i = 0; i < 3; i++) cyc_in(1'b1, 0);
        drain();
        check_eq("imp0_n", outs.size(), 2);
        check_eq("imp0_y0", outs[0], 2);
        check_eq("imp0_y1", outs[1], 0);

        // Full scale negative, long enough for the integrators to wrap.
        do_reset();
        for (int i = 0; i < 1000; i++) cyc_in(1'b1, -32768);
        drain();
        check_stream("fsn");
        check_eq("fsn_first", outs[0], -98304);
        check_eq("fsn_last", outs[outs.size()-1], -131072);

        do_reset();
        for (int i = 0; i < 1000; i++) cyc_in(1'b1, 32767);
        drain();
        check_stream("fsp");
        check_eq("fsp_last", outs[outs.size()-1], 131068);

        // Gated ramp: sample on even cycles only.
        do_reset();
        for (int c = 0; c < 16; c++) cyc_in(c % 2 == 0, 75 * c + 200);
        drain();
        check_stream("ramp");
        check_eq("ramp_y0", outs[0], 750);
        check_eq("ramp_y1", outs[1], 2000);
        check_eq("ramp_period", outc[1] - outc[0], 4);
        check_eq("ramp_hold", int'(d_out), outs[outs.size()-1]);

        // Reset mid-stream with an output pending.
        do_reset();
        for (int i = 0; i < 5; i++) cyc_in(1'b1, 1000);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_d_out", int'(d_out), 0);
        check_eq("mid_g_out", int'(g_out), 0);
        g_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_hold_g", int'(g_out), 0);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        for (int i = 0; i < 6; i++) cyc_in(1'b1, 1000);
        drain();
        check_stream("mid");
        check_eq("mid_first", outs[0], 3000);

        // Random data with random gating.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc_in($urandom_range(0, 2) != 0, int'($urandom_range(0, 65535)) - 32768);
        end
        drain();
        check_stream("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_cic.md
# simple_cic

Parameterized decimating CIC (cascaded integrator-comb) filter for gated sample streams. Input samples arrive on a one-cycle `g_in` strobe at any rate up to one per clock. The block decimates by 2^`rlog` with `n` integrator and comb stages and emits full-precision results on its own `g_out` strobe. It sits after a sample source (ADC/mixer) and feeds slower downstream DSP.

## Interface
- `dw`, 16, input sample width (signed)
- `n`, 2, number of integrator stages and number of comb stages (1..6)
- `rlog`, 1, log2 of decimation ratio R (1..4); comb differential delay M = 1
- `clk`, input, 1, sole clock; all logic on rising edge
- `reset`, input, 1, asynchronous, active-low; clears all state
- `g_in`, input, 1, input sample valid strobe; `d_in` accepted on cycles where high
- `d_in`, input, `dw`, signed two's-complement input sample
- `g_out`, output, 1, one-cycle pulse marking a new `d_out`
- `d_out`, output, `dw`+`n`*`rlog` (18 by default), signed filter output

## Operation
- Internal word width W = `dw` + `n`*`rlog`. All integrator and comb arithmetic is W-bit two's complement, wrapping modulo 2^W. Integrator wrap is intentional and cancelled by the combs. No saturation or rounding.
- Accepted sample k (cycle with `g_in`=1): x[k] is `d_in` sign-extended to W bits.
- Integrators update only on accepted samples and are non-pipelined within the cycle:
  - I1 <= I1 + x
  - Ij <= Ij + (new value of I(j-1))
- Decimation counter of `rlog` bits increments on each accepted sample and wraps. When an accepted sample arrives with counter = R-1, that sample is a decimation event. Decimation events therefore fall on samples k = R-1, 2R-1, …
- Comb section runs once per decimation event, on the cycle after the event, using the updated In:
  - C1 = In - D1, then D1 <= In
  - Cj = C(j-1) - Dj, then Dj <= C(j-1)
  - `d_out` <= Cn
- Resulting transfer function: H(z) = ((1 - z^-R)/(1 - z^-1))^n, evaluated at input-sample rate and decimated. DC gain is R^n.
- Defaults (R=2, n=2): y[m] = x[2m+1] + 2·x[2m] + x[2m-1], with x[-1] = 0.
- Full-scale input never overflows `d_out`: -2^(dw-1)·R^n is the most-negative W-bit value.
- Cycles with `g_in`=0 change no state except the output pipeline.
- `d_out` holds its value between `g_out` pulses.

## Timing
- Reset asserted (`reset`=0): integrators, comb delays, counter, internal strobe, `d_out` and `g_out` all go to 0 immediately and stay 0 while asserted.
- After release, the first accepted sample is k=0 and the counter starts at 0.
- Latency: decimation-event sample accepted at edge E, comb computed in cycle E+1, `d_out`/`g_out` registered at edge E+2. `g_out` is high for exactly one cycle after edge E+2.
- Back-to-back input (`g_in` every cycle) gives a `g_out` pulse every R cycles. `g_in` every other cycle gives one every 2R cycles.
- Reset mid-stream discards all history. Output after release is identical to a fresh start; a pending `g_out` is cancelled.
- `g_in` on the same cycle as reset release is ignored (asynchronous reset dominates at that edge).

## Test plan
- Reset: hold `reset`=0 with `g_in` toggling and `d_in`=1234 → `g_out`=0, `d_out`=0 throughout. Assert `reset` mid-stream → outputs 0 at once; after release, sequence matches a fresh start.
- DC, `g_in` every cycle, `d_in`=1000 → first `g_out` 2 cycles after sample k=1 with `d_out`=3000. All later outputs 4000. `g_out` period 2 cycles.
- Impulse: x[1]=1, all other samples 0 → `d_out` = 1, 1, 0, 0, … (x[0]=1 instead gives 2, 0, 0, …).
- Full scale: DC `d_in`=-32768 → steady `d_out`=-131072. DC `d_in`=32767 → steady 131068. No wrap visible on `d_out` over ≥1000 samples despite integrator wrap.
- Gated ramp: `d_in` = 75·c + 200, `g_in` high on even cycles c → `g_out` every 4 clocks. Each `d_out` equals x[2m+1] + 2x[2m] + x[2m-1] computed from the accepted samples, with no change on idle cycles.
- Random `d_in` with random `g_in` duty → every `d_out` bit-matches a W-bit wrapping reference model of H(z) decimated by R.
